// File: rtl/pic_pkg.sv
// Shared definitions for the programmable interrupt controller.
//   REG_W        register bus data width
//   ADDR_*       register map (3-bit reg_addr)
//   MODE_* bits  fields of the MODE register
//   pic_state_e  handshake FSM states (IDLE/REQ/VEC)
package pic_pkg;

  localparam int REG_W = 32;

  localparam logic [2:0] ADDR_IMR   = 3'd0;
  localparam logic [2:0] ADDR_LTIM  = 3'd1;
  localparam logic [2:0] ADDR_MODE  = 3'd2;
  localparam logic [2:0] ADDR_VBASE = 3'd3;
  localparam logic [2:0] ADDR_EOI   = 3'd4;
  localparam logic [2:0] ADDR_IRR   = 3'd5;
  localparam logic [2:0] ADDR_ISR   = 3'd6;
  localparam logic [2:0] ADDR_PTR   = 3'd7;

  localparam int MODE_AEOI_BIT = 0;
  localparam int MODE_ROT_BIT  = 1;
  localparam int EOI_SPEC_BIT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_VEC  = 2'd2
  } pic_state_e;

endpackage

// File: rtl/irq_prio_resolver.sv
// Combinational priority resolver.
//   req      pending, unmasked requests
//   isr      in-service bits
//   ptr      lowest-priority id; id (ptr+1) mod NUM_IRQ is highest
//   found    a request exists strictly above the highest in-service bit
//   id       winning request id (meaningful when found)
//   isr_any  at least one in-service bit set
//   isr_top  highest-priority in-service id (meaningful when isr_any)
module irq_prio_resolver
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0]         req,
  input  logic [NUM_IRQ-1:0]         isr,
  input  logic [$clog2(NUM_IRQ)-1:0] ptr,
  output logic                       found,
  output logic [$clog2(NUM_IRQ)-1:0] id,
  output logic                       isr_any,
  output logic [$clog2(NUM_IRQ)-1:0] isr_top
);

  localparam int PW = $clog2(NUM_IRQ);

  // Rank k = 0 is the highest-priority slot. Walking from the lowest rank
  // upward leaves the highest-priority hit in the result.
  int            req_k;
  int            isr_k;
  logic [PW-1:0] idx;

  always_comb begin
    req_k   = NUM_IRQ;
    isr_k   = NUM_IRQ;
    id      = '0;
    isr_top = '0;
    idx     = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + 1 + k) % NUM_IRQ);
      if (req[idx]) begin
        req_k = k;
        id    = idx;
      end
      if (isr[idx]) begin
        isr_k   = k;
        isr_top = idx;
      end
    end
    // An empty req leaves req_k = NUM_IRQ, which can never be below isr_k.
    found   = (req_k < isr_k);
    isr_any = (isr_k < NUM_IRQ);
  end

endmodule

// File: rtl/pic_irq_ctrl_n.sv
// Parametrised 8259-style interrupt controller.
//   clk, rst          clock, asynchronous active-high reset
//   irq_in            raw peripheral request lines
//   reg_we/re/addr    register bus strobes and select
//   reg_wdata/rdata   register bus data (rdata registered, holds between reads)
//   int_req           interrupt request to the CPU
//   int_ack           one-cycle INTA pulse
//   vec_out/vec_valid vector (VEC_BASE + id), one-cycle valid pulse
//   spurious          with vec_valid: acknowledge found nothing pending
//   state_dbg         current handshake FSM state
//
// Handshake: int_req is a level that stays high while a candidate exists;
// the CPU answers with a single-cycle int_ack, at which point the winner is
// frozen and the vector appears with vec_valid exactly one cycle later.
// int_ack while the vector is being presented is ignored.
module pic_irq_ctrl_n
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 8,
  parameter int SYNC_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [2:0]         reg_addr,
  input  logic [REG_W-1:0]   reg_wdata,
  output logic [REG_W-1:0]   reg_rdata,
  output logic               int_req,
  input  logic               int_ack,
  output logic [VEC_W-1:0]   vec_out,
  output logic               vec_valid,
  output logic               spurious,
  output pic_state_e         state_dbg
);

  localparam int            PW      = $clog2(NUM_IRQ);
  localparam logic [PW-1:0] PTR_MAX = PW'(NUM_IRQ - 1);

  logic [NUM_IRQ-1:0] irq_s, irq_d, rise;
  logic [NUM_IRQ-1:0] imr_q, ltim_q, irr_edge_q, isr_q;
  logic [NUM_IRQ-1:0] irr, pending;
  logic [NUM_IRQ-1:0] ack_mask, eoi_mask, aeoi_mask;
  logic [1:0]         mode_q;
  logic [VEC_W-1:0]   vbase_q;
  logic [PW-1:0]      ptr_q, win_q;
  logic               win_found_q;
  pic_state_e         state_q, state_n;

  logic               cand_found, isr_any;
  logic [PW-1:0]      cand_id, isr_top;
  logic               ack_take, ack_hit, aeoi_vec;
  logic               wr_eoi, eoi_hit, rot_next;
  logic [PW-1:0]      eoi_id;
  logic [REG_W-1:0]   rd_mux;
  logic               unused_wdata;

  assign unused_wdata = ^reg_wdata;

  // Input synchroniser (optional)
  generate
    if (SYNC_EN != 0) begin : g_sync
      logic [NUM_IRQ-1:0] s1_q, s2_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_q <= '0;
          s2_q <= '0;
        end else begin
          s1_q <= irq_in;
          s2_q <= s1_q;
        end
      end
      assign irq_s = s2_q;
    end else begin : g_nosync
      assign irq_s = irq_in;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_d <= '0;
    else     irq_d <= irq_s;
  end

  assign rise    = irq_s & ~irq_d;
  // Level lines follow the synchronised input directly; edge lines latch.
  assign irr     = (ltim_q & irq_s) | (~ltim_q & irr_edge_q);
  assign pending = irr & ~imr_q;

  irq_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_resolver (
    .req     (pending),
    .isr     (isr_q),
    .ptr     (ptr_q),
    .found   (cand_found),
    .id      (cand_id),
    .isr_any (isr_any),
    .isr_top (isr_top)
  );

  assign ack_take = int_ack && (state_q != ST_VEC);
  assign ack_hit  = ack_take && cand_found;
  assign aeoi_vec = (state_q == ST_VEC) && win_found_q && mode_q[MODE_AEOI_BIT];
  assign wr_eoi   = reg_we && (reg_addr == ADDR_EOI);
  // Fixed mode pins the pointer; leaving rotate mode snaps it back at once.
  assign rot_next = (reg_we && reg_addr == ADDR_MODE) ? reg_wdata[MODE_ROT_BIT]
                                                      : mode_q[MODE_ROT_BIT];

  // EOI decode: specific EOI only acts on a bit that is actually in service.
  always_comb begin
    eoi_hit = 1'b0;
    eoi_id  = '0;
    if (wr_eoi) begin
      if (reg_wdata[EOI_SPEC_BIT]) begin
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (int'(reg_wdata[4:0]) == i && isr_q[i]) begin
            eoi_hit = 1'b1;
            eoi_id  = PW'(i);
          end
        end
      end else begin
        eoi_hit = isr_any;
        eoi_id  = isr_top;
      end
    end
  end

  always_comb begin
    ack_mask  = '0;
    eoi_mask  = '0;
    aeoi_mask = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_mask[i]  = ack_hit && (cand_id == PW'(i));
      eoi_mask[i]  = eoi_hit && (eoi_id == PW'(i));
      aeoi_mask[i] = aeoi_vec && (win_q == PW'(i));
    end
  end

  // Handshake FSM: next state
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: begin
        if (int_ack)         state_n = ST_VEC;
        else if (cand_found) state_n = ST_REQ;
      end
      ST_REQ: begin
        if (int_ack)          state_n = ST_VEC;
        else if (!cand_found) state_n = ST_IDLE;
      end
      ST_VEC:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      int_req     <= 1'b0;
      vec_valid   <= 1'b0;
      spurious    <= 1'b0;
      vec_out     <= '0;
      win_q       <= '0;
      win_found_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      int_req   <= (state_n == ST_REQ);
      vec_valid <= (state_n == ST_VEC);
      spurious  <= ack_take && !cand_found;
      if (ack_take) begin
        win_q       <= cand_id;
        win_found_q <= cand_found;
        vec_out     <= cand_found ? (vbase_q + VEC_W'(cand_id))
                                  : (vbase_q + VEC_W'(NUM_IRQ - 1));
      end
    end
  end

  assign state_dbg = state_q;

  // Interrupt state and programmable registers. Ack set beats EOI clear and
  // a new edge beats the ack clear, hence the order of the terms below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imr_q      <= '1;
      ltim_q     <= '0;
      mode_q     <= '0;
      vbase_q    <= '0;
      irr_edge_q <= '0;
      isr_q      <= '0;
      ptr_q      <= PTR_MAX;
    end else begin
      irr_edge_q <= ~ltim_q & ((irr_edge_q & ~ack_mask) | rise);
      isr_q      <= (isr_q & ~eoi_mask & ~aeoi_mask)
                  | (mode_q[MODE_AEOI_BIT] ? '0 : ack_mask);

      if (!rot_next)                         ptr_q <= PTR_MAX;
      else if (eoi_hit && mode_q[MODE_ROT_BIT])  ptr_q <= eoi_id;
      else if (aeoi_vec && mode_q[MODE_ROT_BIT]) ptr_q <= win_q;

      if (reg_we) begin
        case (reg_addr)
          ADDR_IMR:   imr_q   <= reg_wdata[NUM_IRQ-1:0];
          ADDR_LTIM:  ltim_q  <= reg_wdata[NUM_IRQ-1:0];
          ADDR_MODE:  mode_q  <= reg_wdata[1:0];
          ADDR_VBASE: vbase_q <= reg_wdata[VEC_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Register read path
  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_IMR:   rd_mux[NUM_IRQ-1:0] = imr_q;
      ADDR_LTIM:  rd_mux[NUM_IRQ-1:0] = ltim_q;
      ADDR_MODE:  rd_mux[1:0]         = mode_q;
      ADDR_VBASE: rd_mux[VEC_W-1:0]   = vbase_q;
      ADDR_IRR:   rd_mux[NUM_IRQ-1:0] = irr;
      ADDR_ISR:   rd_mux[NUM_IRQ-1:0] = isr_q;
      ADDR_PTR:   rd_mux[PW-1:0]      = ptr_q;
      default:    rd_mux              = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         reg_rdata <= '0;
    else if (reg_re) reg_rdata <= rd_mux;
  end

endmodule
